// File: rtl/unidade_controle_param.sv
// Control unit for the memory-sequence game.
// It owns the round and play counters, the inactivity timer and the life counter. It drives
// the address and the register/memory strobes to the datapath.
// Ports:
//   clock, reset            clock; asynchronous active-high reset
//   iniciar                 start/restart (sampled in inicial and in final states)
//   modo                    0 = fixed sequence, 1 = write mode (latched in inicializa)
//   jogada                  one-cycle button-press pulse
//   jogada_igual            comparator result for the registered jogada
//   endereco                memory address
//   rodada                  current round (0-based)
//   zeraR/registraR         clear/load the jogada register
//   escreveM                memory write enable
//   vidas_restantes         lives left
//   ganhou/perdeu/timeout   final-state flags; pronto is high in any final state
//   db_estado               state code, for debug
module unidade_controle_param #(
  parameter int unsigned N_RODADAS = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned TIMEOUT   = 5000,
  parameter int unsigned VIDAS     = 3,
  parameter int unsigned VW        = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          modo,
  input  logic          jogada,
  input  logic          jogada_igual,
  output logic [AW-1:0] endereco,
  output logic [AW-1:0] rodada,
  output logic          zeraR,
  output logic          registraR,
  output logic          escreveM,
  output logic [VW-1:0] vidas_restantes,
  output logic          ganhou,
  output logic          perdeu,
  output logic          timeout,
  output logic          pronto,
  output logic [3:0]    db_estado
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    StInicial       = 4'h0,
    StInicializa    = 4'h1,
    StInicioRodada  = 4'h2,
    StEsperaJogada  = 4'h3,
    StRegistra      = 4'h4,
    StCompara       = 4'h5,
    StProximaJogada = 4'h6,
    StFimRodada     = 4'h7,
    StEsperaEscrita = 4'h8,
    StEscreve       = 4'h9,
    StFinalAcertos  = 4'hA,
    StProximaRodada = 4'hB,
    StPerdeVida     = 4'hC,
    StFinalErro     = 4'hE,
    StFinalTimeout  = 4'hF
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   jogada_q;
  logic [AW-1:0]   rodada_q;
  logic [VW-1:0]   vidas_q;
  logic [TW-1:0]   timer_q;
  logic            modo_q;
  logic            timer_fim;

  assign timer_fim = (timer_q == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StInicial;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StInicial:       if (iniciar) state_d = StInicializa;
      StInicializa:    state_d = StInicioRodada;
      StInicioRodada:  state_d = StEsperaJogada;
      // A press on the same cycle the timer expires takes priority.
      StEsperaJogada: begin
        if (jogada)         state_d = StRegistra;
        else if (timer_fim) state_d = StFinalTimeout;
      end
      StRegistra:      state_d = StCompara;
      StCompara: begin
        if (!jogada_igual)            state_d = StPerdeVida;
        else if (jogada_q == rodada_q) state_d = StFimRodada;
        else                          state_d = StProximaJogada;
      end
      StProximaJogada: state_d = StEsperaJogada;
      StFimRodada: begin
        if (rodada_q == AW'(N_RODADAS - 1)) state_d = StFinalAcertos;
        else if (modo_q)                    state_d = StEsperaEscrita;
        else                                state_d = StProximaRodada;
      end
      StEsperaEscrita: begin
        if (jogada)         state_d = StEscreve;
        else if (timer_fim) state_d = StFinalTimeout;
      end
      StEscreve:       state_d = StProximaRodada;
      StProximaRodada: state_d = StInicioRodada;
      // The failed round is replayed from its start while lives remain.
      StPerdeVida: begin
        if (vidas_q == VW'(1)) state_d = StFinalErro;
        else                   state_d = StInicioRodada;
      end
      StFinalAcertos, StFinalErro, StFinalTimeout: begin
        if (iniciar) state_d = StInicializa;
      end
      default:         state_d = StInicial;
    endcase
  end

  // Counters, timer and latched mode, updated from the current state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogada_q <= '0;
      rodada_q <= '0;
      vidas_q  <= '0;
      timer_q  <= '0;
      modo_q   <= 1'b0;
    end else begin
      if (state_q == StEsperaJogada || state_q == StEsperaEscrita) begin
        timer_q <= timer_q + TW'(1);
      end else begin
        timer_q <= '0;
      end
      case (state_q)
        StInicializa: begin
          jogada_q <= '0;
          rodada_q <= '0;
          vidas_q  <= VW'(VIDAS);
          modo_q   <= modo;
        end
        // Clearing jogada before entering inicio_rodada keeps endereco at 0 there.
        StInicioRodada, StProximaRodada: begin
          jogada_q <= '0;
          if (state_q == StProximaRodada) rodada_q <= rodada_q + AW'(1);
        end
        StProximaJogada: jogada_q <= jogada_q + AW'(1);
        StPerdeVida: begin
          jogada_q <= '0;
          vidas_q  <= vidas_q - VW'(1);
        end
        default: ;
      endcase
    end
  end

  // Moore outputs.
  always_comb begin
    zeraR     = (state_q == StInicial) || (state_q == StInicializa);
    registraR = (state_q == StRegistra);
    escreveM  = (state_q == StEscreve);
    ganhou    = (state_q == StFinalAcertos);
    perdeu    = (state_q == StFinalErro);
    timeout   = (state_q == StFinalTimeout);
    pronto    = ganhou || perdeu || timeout;
    // While appending a jogada, the write goes just past the current round.
    if (state_q == StEsperaEscrita || state_q == StEscreve) begin
      endereco = rodada_q + AW'(1);
    end else begin
      endereco = jogada_q;
    end
    rodada          = rodada_q;
    vidas_restantes = vidas_q;
    db_estado       = state_q;
  end

endmodule

// File: tb/tb_unidade_controle_param.sv
module tb_unidade_controle_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, modo, jogada, jogada_igual;
  logic [3:0] endereco, rodada;
  logic       zeraR, registraR, escreveM;
  logic [1:0] vidas_restantes;
  logic       ganhou, perdeu, timeout, pronto;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  unidade_controle_param #(
    .N_RODADAS(4), .AW(4), .TIMEOUT(8), .VIDAS(3), .VW(2)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo(modo), .jogada(jogada),
    .jogada_igual(jogada_igual), .endereco(endereco), .rodada(rodada), .zeraR(zeraR),
    .registraR(registraR), .escreveM(escreveM), .vidas_restantes(vidas_restantes),
    .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .pronto(pronto),
    .db_estado(db_estado)
  );

  typedef struct {
    logic       ini, mo, jog, ig;
    logic [3:0] st, rod, ende;
    logic [1:0] vid;
    logic [2:0] strb;  // {zeraR, registraR, escreveM}
    logic [3:0] fin;   // {ganhou, perdeu, timeout, pronto}
  } vec_t;

  vec_t vecs[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs are settled #1 after the edge.
  task automatic cyc(input logic i, input logic m, input logic j, input logic g);
    @(negedge clock);
    iniciar = i; modo = m; jogada = j; jogada_igual = g;
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic i, input logic m, input logic j, input logic g,
                              input logic [3:0] st, input logic [3:0] rod,
                              input logic [3:0] ende, input logic [1:0] vid,
                              input logic [2:0] strb, input logic [3:0] fin);
    vec_t v;
    v.ini = i; v.mo = m; v.jog = j; v.ig = g; v.st = st; v.rod = rod; v.ende = ende;
    v.vid = vid; v.strb = strb; v.fin = fin;
    return v;
  endfunction

  initial begin
    // Write-mode round 0, then round 1 lost three times, then restart from final_erro.
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 4'd0, 4'd0, 2'd0, 3'b100, 4'b0000);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 4'd0, 4'd0, 2'd3, 3'b000, 4'b0000);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'd0, 4'd0, 2'd3, 3'b000, 4'b0000);
    vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 4'd0, 4'd0, 2'd3, 3'b010, 4'b0000);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'd0, 4'd0, 2'd3, 3'b000, 4'b0000);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 4'd0, 4'd0, 2'd3, 3'b000, 4'b0000);
    vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 4'd0, 4'd1, 2'd3, 3'b000, 4'b0000);
    vecs[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h9, 4'd0, 4'd1, 2'd3, 3'b001, 4'b0000);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hB, 4'd0, 4'd0, 2'd3, 3'b000, 4'b0000);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'd1, 4'd0, 2'd3, 3'b000, 4'b0000);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'd1, 4'd0, 2'd3, 3'b000, 4'b0000);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 4'd1, 4'd0, 2'd3, 3'b010, 4'b0000);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'd1, 4'd0, 2'd3, 3'b000, 4'b0000);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 4'd1, 4'd0, 2'd3, 3'b000, 4'b0000);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'd1, 4'd1, 2'd3, 3'b000, 4'b0000);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 4'd1, 4'd1, 2'd3, 3'b010, 4'b0000);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'd1, 4'd1, 2'd3, 3'b000, 4'b0000);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 4'd1, 4'd1, 2'd3, 3'b000, 4'b0000);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'd1, 4'd0, 2'd2, 3'b000, 4'b0000);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'd1, 4'd0, 2'd2, 3'b000, 4'b0000);
    vecs[20] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 4'd1, 4'd0, 2'd2, 3'b010, 4'b0000);
    vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'd1, 4'd0, 2'd2, 3'b000, 4'b0000);
    vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 4'd1, 4'd0, 2'd2, 3'b000, 4'b0000);
    vecs[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'd1, 4'd0, 2'd1, 3'b000, 4'b0000);
    vecs[24] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'd1, 4'd0, 2'd1, 3'b000, 4'b0000);
    vecs[25] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 4'd1, 4'd0, 2'd1, 3'b010, 4'b0000);
    vecs[26] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'd1, 4'd0, 2'd1, 3'b000, 4'b0000);
    vecs[27] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 4'd1, 4'd0, 2'd1, 3'b000, 4'b0000);
    vecs[28] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd1, 4'd0, 2'd0, 3'b000, 4'b0101);
    vecs[29] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'hE, 4'd1, 4'd0, 2'd0, 3'b000, 4'b0101);
    vecs[30] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 4'd1, 4'd0, 2'd0, 3'b100, 4'b0000);
    vecs[31] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'd0, 4'd0, 2'd3, 3'b000, 4'b0000);

    reset = 1'b1; iniciar = 1'b0; modo = 1'b0; jogada = 1'b0; jogada_igual = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 32'(db_estado), 32'h0);
    check("reset_zeraR", 32'(zeraR), 32'd1);
    check("reset_vidas", 32'(vidas_restantes), 32'd0);
    check("reset_flags", 32'({registraR, escreveM, pronto}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Table: write mode, life loss and restart.
    for (int k = 0; k < 32; k++) begin
      cyc(vecs[k].ini, vecs[k].mo, vecs[k].jog, vecs[k].ig);
      check($sformatf("vec%0d_state", k), 32'(db_estado), 32'(vecs[k].st));
      check($sformatf("vec%0d_rodada", k), 32'(rodada), 32'(vecs[k].rod));
      check($sformatf("vec%0d_endereco", k), 32'(endereco), 32'(vecs[k].ende));
      check($sformatf("vec%0d_vidas", k), 32'(vidas_restantes), 32'(vecs[k].vid));
      check($sformatf("vec%0d_strobes", k), 32'({zeraR, registraR, escreveM}),
            32'(vecs[k].strb));
      check($sformatf("vec%0d_final", k), 32'({ganhou, perdeu, timeout, pronto}),
            32'(vecs[k].fin));
    end

    // Full win in fixed mode: round r needs r+1 correct jogadas.
    for (int r = 0; r < 4; r++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j <= r; j++) begin
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check($sformatf("win_r%0d_j%0d_reg", r, j), 32'(db_estado), 32'h4);
        check($sformatf("win_r%0d_j%0d_end", r, j), 32'(endereco), 32'(j));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check($sformatf("win_r%0d_j%0d_cmp", r, j), 32'(db_estado), (j == r) ? 32'h7 : 32'h6);
        if (j < r) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
      if (r < 3) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check($sformatf("win_r%0d_next", r), 32'(rodada), 32'(r + 1));
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("win_state", 32'(db_estado), 32'hA);
    check("win_flags", 32'({ganhou, perdeu, timeout, pronto}), 32'b1001);
    check("win_rodada", 32'(rodada), 32'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("win_hold", 32'(db_estado), 32'hA);

    // Timeout on the 8th idle cycle.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_before", 32'(db_estado), 32'h3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_state", 32'(db_estado), 32'hF);
    check("to_flags", 32'({ganhou, perdeu, timeout, pronto}), 32'b0011);

    // A press on the expiring cycle wins over timeout.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("to_restart_vidas", 32'(db_estado), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("to_race", 32'(db_estado), 32'h4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("to_race_cmp", 32'(db_estado), 32'h7);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_race_round", 32'(rodada), 32'd1);

    // Asynchronous reset while in compara.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_pre", 32'(db_estado), 32'h5);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_async_state", 32'(db_estado), 32'h0);
    check("rst_async_zeraR", 32'(zeraR), 32'd1);
    check("rst_async_vidas", 32'(vidas_restantes), 32'd0);
    check("rst_async_rodada", 32'(rodada), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_reload_vidas", 32'(vidas_restantes), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
